// File: rtl/io1out_pad.sv
// io1out_pad: 1-bit output pad. Selects one of four tile-side sources, can
// register it, and drives the package pin behind an output-enable turnaround
// guard. The guard keeps the pad from driving while another driver may still
// be active.
module io1out_pad #(
    parameter int   TURN_CYCLES = 2,
    parameter logic INIT_VALUE  = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pin_0,
    input  logic       pin_1,
    input  logic       pin_2,
    input  logic       pin_3,
    input  logic       config_en,
    input  logic [3:0] config_data,
    output logic [0:0] top_pin,
    output logic       top_pin_oe
);

    // The counter is loaded with TURN_CYCLES-1, so it only has to hold that value.
    localparam int CNT_W = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD =
        (TURN_CYCLES > 0) ? CNT_W'(TURN_CYCLES - 1) : CNT_W'(0);

    typedef enum logic [1:0] {
        ST_OFF   = 2'b00,
        ST_ARM   = 2'b01,
        ST_DRIVE = 2'b10
    } state_t;

    logic [1:0]       r_sel;
    logic             r_reg_mode;
    logic             r_oe_en;
    logic             r_data_q;
    logic             r_oe;
    logic [CNT_W-1:0] r_cnt;
    state_t           r_state;
    logic             w_mux_out;

    // Configuration register: all four fields load together on a write strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel      <= 2'd0;
            r_reg_mode <= 1'b0;
            r_oe_en    <= 1'b0;
        end else if (config_en) begin
            r_sel      <= config_data[1:0];
            r_reg_mode <= config_data[2];
            r_oe_en    <= config_data[3];
        end
    end

    // Source select across the four tile sides.
    always_comb begin
        w_mux_out = pin_0;
        case (r_sel)
            2'd0: w_mux_out = pin_0;
            2'd1: w_mux_out = pin_1;
            2'd2: w_mux_out = pin_2;
            2'd3: w_mux_out = pin_3;
            default: w_mux_out = pin_0;
        endcase
    end

    // Free-running capture of the selected source, used in registered mode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data_q <= INIT_VALUE;
        end else begin
            r_data_q <= w_mux_out;
        end
    end

    // OE turnaround FSM. r_oe is updated together with the state, so it is
    // high exactly when the state is DRIVE and comes straight from a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_OFF;
            r_cnt   <= CNT_W'(0);
            r_oe    <= 1'b0;
        end else begin
            case (r_state)
                ST_OFF: begin
                    if (r_oe_en) begin
                        if (TURN_CYCLES == 0) begin
                            r_state <= ST_DRIVE;
                            r_oe    <= 1'b1;
                        end else begin
                            r_state <= ST_ARM;
                            r_cnt   <= CNT_LOAD;
                            r_oe    <= 1'b0;
                        end
                    end
                end
                ST_ARM: begin
                    // Abort wins over completion of the guard interval.
                    if (!r_oe_en) begin
                        r_state <= ST_OFF;
                        r_oe    <= 1'b0;
                    end else if (r_cnt == CNT_W'(0)) begin
                        r_state <= ST_DRIVE;
                        r_oe    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_DRIVE: begin
                    // Release is immediate; only the turn-on is guarded.
                    if (!r_oe_en) begin
                        r_state <= ST_OFF;
                        r_oe    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_OFF;
                    r_oe    <= 1'b0;
                end
            endcase
        end
    end

    assign top_pin_oe = r_oe;
    // Bypass mode passes the source through with no latency; registered mode adds one cycle.
    assign top_pin[0] = r_oe ? (r_reg_mode ? r_data_q : w_mux_out) : INIT_VALUE;

endmodule

// File: tb/tb_io1out_pad.sv
// Bench for io1out_pad: a table of per-cycle vectors for the default
// TURN_CYCLES=2 pad, plus short sequences for latency, reset and TURN_CYCLES=0.
module tb_io1out_pad;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] p;
    logic       config_en;
    logic [3:0] config_data;
    logic [0:0] top_pin;
    logic       top_pin_oe;
    logic [0:0] top_pin_z;
    logic       top_pin_oe_z;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    io1out_pad #(.TURN_CYCLES(2), .INIT_VALUE(1'b0)) dut (
        .clk(clk), .rst(rst),
        .pin_0(p[0]), .pin_1(p[1]), .pin_2(p[2]), .pin_3(p[3]),
        .config_en(config_en), .config_data(config_data),
        .top_pin(top_pin), .top_pin_oe(top_pin_oe)
    );

    io1out_pad #(.TURN_CYCLES(0), .INIT_VALUE(1'b0)) dut0 (
        .clk(clk), .rst(rst),
        .pin_0(p[0]), .pin_1(p[1]), .pin_2(p[2]), .pin_3(p[3]),
        .config_en(config_en), .config_data(config_data),
        .top_pin(top_pin_z), .top_pin_oe(top_pin_oe_z)
    );

    typedef struct {
        logic       cen;
        logic [3:0] cfg;
        logic [3:0] pins;
        logic       oe;
        logic       pin;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs[NV];

    task automatic chk(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: inputs already driven, wait for the edge, return on the next negedge.
    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // {config_en, config_data, pins[3:0], expected oe, expected top_pin}
        // Turnaround with TURN_CYCLES=2, bypass, sel=0
        vecs[0]  = '{1'b1, 4'b1000, 4'b0001, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 4'b0000, 4'b0001, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 4'b0000, 4'b0001, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 4'b0000, 4'b0001, 1'b1, 1'b1};
        vecs[4]  = '{1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 4'b0000, 4'b0001, 1'b1, 1'b1};
        // Switch to registered, sel=1, while driving (oe_en rewrite keeps DRIVE)
        vecs[6]  = '{1'b1, 4'b1101, 4'b0001, 1'b1, 1'b1};
        vecs[7]  = '{1'b0, 4'b0000, 4'b0001, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 4'b0000, 4'b0011, 1'b1, 1'b1};
        vecs[9]  = '{1'b0, 4'b0000, 4'b0001, 1'b1, 1'b0};
        // Reselect 1 -> 3 in registered mode, pin_1=0, pin_3=1
        vecs[10] = '{1'b1, 4'b1111, 4'b1001, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 4'b0000, 4'b1001, 1'b1, 1'b1};
        // Release: OE drops one edge after the config takes effect
        vecs[12] = '{1'b1, 4'b0000, 4'b1001, 1'b1, 1'b1};
        vecs[13] = '{1'b0, 4'b0000, 4'b1001, 1'b0, 1'b0};
        // Abort during ARM
        vecs[14] = '{1'b1, 4'b1000, 4'b0001, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 4'b0000, 4'b0001, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 4'b0000, 4'b0001, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 4'b0000, 4'b0001, 1'b0, 1'b0};
        vecs[18] = '{1'b0, 4'b0000, 4'b0001, 1'b0, 1'b0};
        // Rewrite oe_en=1 while in ARM: counter must not restart
        vecs[19] = '{1'b1, 4'b1000, 4'b0001, 1'b0, 1'b0};
        vecs[20] = '{1'b0, 4'b0000, 4'b0001, 1'b0, 1'b0};
        vecs[21] = '{1'b1, 4'b1000, 4'b0001, 1'b0, 1'b0};
        vecs[22] = '{1'b0, 4'b0000, 4'b0001, 1'b1, 1'b1};
        vecs[23] = '{1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0};

        rst         = 1'b1;
        p           = 4'b0000;
        config_en   = 1'b0;
        config_data = 4'b0000;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("reset_oe", top_pin_oe, 1'b0);
        chk("reset_pin", top_pin[0], 1'b0);
        chk("reset_oe_t0", top_pin_oe_z, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Table-driven vectors
        for (int i = 0; i < NV; i++) begin
            config_en   = vecs[i].cen;
            config_data = vecs[i].cfg;
            p           = vecs[i].pins;
            cycle();
            chk($sformatf("vec%0d_oe", i), top_pin_oe, vecs[i].oe);
            chk($sformatf("vec%0d_pin", i), top_pin[0], vecs[i].pin);
        end
        config_en = 1'b0;

        // Bypass: pin change visible without any clock edge
        p = 4'b0001;
        #1;
        chk("bypass_same_cycle", top_pin[0], 1'b1);
        @(negedge clk);

        // Registered mode sel=0: pin change visible only after the next edge
        config_en   = 1'b1;
        config_data = 4'b1100;
        cycle();
        config_en = 1'b0;
        chk("reg_entry_oe", top_pin_oe, 1'b1);
        chk("reg_entry_pin", top_pin[0], 1'b1);
        p = 4'b0000;
        #1;
        chk("reg_hold_before_edge", top_pin[0], 1'b1);
        @(posedge clk);
        #1;
        chk("reg_after_edge", top_pin[0], 1'b0);
        @(negedge clk);

        // Reset mid-DRIVE with sel=2, pin_2=1, bypass
        config_en   = 1'b1;
        config_data = 4'b1010;
        p           = 4'b0100;
        cycle();
        config_en = 1'b0;
        chk("pre_rst_oe", top_pin_oe, 1'b1);
        chk("pre_rst_pin", top_pin[0], 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_oe", top_pin_oe, 1'b0);
        chk("async_rst_pin", top_pin[0], 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk($sformatf("post_rst%0d_oe", k), top_pin_oe, 1'b0);
            chk($sformatf("post_rst%0d_pin", k), top_pin[0], 1'b0);
        end

        // TURN_CYCLES=0 pad: drive next cycle; also an abort at ARM for the default pad
        p           = 4'b0001;
        config_en   = 1'b1;
        config_data = 4'b1000;
        cycle();
        config_en = 1'b0;
        chk("t0_after_E0_oe", top_pin_oe_z, 1'b0);
        cycle();
        chk("t0_after_E1_oe", top_pin_oe_z, 1'b1);
        chk("t0_after_E1_pin", top_pin_z[0], 1'b1);
        chk("t2_after_E1_oe", top_pin_oe, 1'b0);
        config_en   = 1'b1;
        config_data = 4'b0000;
        cycle();
        config_en = 1'b0;
        chk("t0_after_E2_oe", top_pin_oe_z, 1'b1);
        chk("t2_after_E2_oe", top_pin_oe, 1'b0);
        cycle();
        chk("t0_after_E3_oe", top_pin_oe_z, 1'b0);
        chk("t0_after_E3_pin", top_pin_z[0], 1'b0);
        chk("t2_after_E3_oe", top_pin_oe, 1'b0);
        cycle();
        chk("t2_after_E4_oe", top_pin_oe, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
